// File: rtl/proj_lut_eval_if.sv
// Configuration and evaluation streams for proj_lut_eval.
// The master drives the requests and the slave (the evaluator) answers them.
interface proj_lut_eval_if #(
    parameter int N_IN   = 14,
    parameter int K_PROJ = 5,
    parameter int SEL_W  = $clog2(N_IN)
);
    logic                      cfg_start;
    logic [K_PROJ*SEL_W-1:0]   cfg_sel;
    logic                      cfg_inv;
    logic                      cfg_ready;
    logic                      cfg_bit_vld;
    logic                      cfg_bit;
    logic                      cfg_done;
    logic                      cfg_err;
    logic                      in_valid;
    logic                      in_ready;
    logic [N_IN-1:0]           x;
    logic                      out_valid;
    logic                      out_ready;
    logic                      y;

    modport master (
        output cfg_start, cfg_sel, cfg_inv, cfg_bit_vld, cfg_bit,
        output in_valid, x, out_ready,
        input  cfg_ready, cfg_done, cfg_err, in_ready, out_valid, y
    );

    modport slave (
        input  cfg_start, cfg_sel, cfg_inv, cfg_bit_vld, cfg_bit,
        input  in_valid, x, out_ready,
        output cfg_ready, cfg_done, cfg_err, in_ready, out_valid, y
    );
endinterface

// File: rtl/proj_lut_eval.sv
// Programmable projection evaluator: y = lut[x projected onto K_PROJ selected bits] ^ inv.
// The truth table is loaded serially; evaluation is a two-stage valid/ready pipeline.
module proj_lut_eval #(
    parameter int N_IN   = 14,
    parameter int K_PROJ = 5,
    parameter int SEL_W  = $clog2(N_IN)
) (
    input  logic           clk,
    input  logic           rst_n,
    proj_lut_eval_if.slave bus
);
    localparam int LUT_N = 1 << K_PROJ;
    localparam int XP_W  = 1 << SEL_W;

    localparam logic [1:0] ST_UNCFG = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [LUT_N-1:0]        lut_q, lut_d;
    logic [K_PROJ*SEL_W-1:0] sel_q, sel_d;
    logic                    inv_q, inv_d;
    logic [K_PROJ-1:0]       cnt_q, cnt_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    s1_v_q, s1_v_d;
    logic [K_PROJ-1:0]       idx_q, idx_d;
    logic                    s2_v_q, s2_v_d;
    logic                    y_q, y_d;

    logic                    cfg_ready;
    logic                    sel_bad;
    logic                    start_take;
    logic                    restart;
    logic                    s2_open;
    logic                    in_ready;
    logic                    in_fire;
    logic [XP_W-1:0]         x_pad;

    // Padding x to the full select range keeps every index in bounds.
    assign x_pad      = XP_W'(bus.x);
    assign cfg_ready  = (state_q != ST_LOAD) && !s1_v_q && !s2_v_q;
    assign start_take = bus.cfg_start && (cfg_ready || state_q == ST_LOAD);
    assign restart    = start_take && !sel_bad;
    assign s2_open    = !s2_v_q || bus.out_ready;
    assign in_ready   = (state_q == ST_RUN) && (!s1_v_q || s2_open);
    assign in_fire    = bus.in_valid && in_ready;

    always_comb begin
        sel_bad = 1'b0;
        for (int j = 0; j < K_PROJ; j++) begin
            if (32'(bus.cfg_sel[j*SEL_W +: SEL_W]) >= 32'(N_IN)) sel_bad = 1'b1;
        end
    end

    // A start with a bad select is consumed but only flags the error.
    always_comb begin
        state_d = state_q;
        lut_d   = lut_q;
        sel_d   = sel_q;
        inv_d   = inv_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        if (start_take) err_d = sel_bad;
        if (restart) begin
            sel_d   = bus.cfg_sel;
            inv_d   = bus.cfg_inv;
            cnt_d   = '0;
            state_d = ST_LOAD;
        end else if (state_q == ST_LOAD && bus.cfg_bit_vld) begin
            lut_d[cnt_q] = bus.cfg_bit;
            cnt_d        = cnt_q + 1'b1;
            if (&cnt_q) begin
                done_d  = 1'b1;
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        s1_v_d = s1_v_q;
        idx_d  = idx_q;
        s2_v_d = s2_v_q;
        y_d    = y_q;
        if (in_fire) begin
            s1_v_d = 1'b1;
            for (int j = 0; j < K_PROJ; j++) begin
                idx_d[j] = x_pad[sel_q[j*SEL_W +: SEL_W]];
            end
        end else if (s2_open) begin
            s1_v_d = 1'b0;
        end
        if (s2_open) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) y_d = lut_q[idx_q] ^ inv_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_UNCFG;
            lut_q   <= '0;
            sel_q   <= '0;
            inv_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            s1_v_q  <= 1'b0;
            idx_q   <= '0;
            s2_v_q  <= 1'b0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            lut_q   <= lut_d;
            sel_q   <= sel_d;
            inv_q   <= inv_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            s1_v_q  <= s1_v_d;
            idx_q   <= idx_d;
            s2_v_q  <= s2_v_d;
            y_q     <= y_d;
        end
    end

    assign bus.cfg_ready = cfg_ready;
    assign bus.cfg_done  = done_q;
    assign bus.cfg_err   = err_q;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_v_q;
    assign bus.y         = y_q;
endmodule

// File: tb/tb_proj_lut_eval.sv
// Testbench for proj_lut_eval: directed scenarios plus randomized traffic,
// with every output compared against a truth-table model of the block.
module tb_proj_lut_eval;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    proj_lut_eval_if #(.N_IN(14), .K_PROJ(5)) bus ();

    proj_lut_eval #(.N_IN(14), .K_PROJ(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          out_count = 0;
    int          done_count = 0;
    logic        exp_q[$];
    logic        hold_pending = 1'b0;
    logic        hold_y = 1'b0;
    int          m_sel[5];
    logic        m_inv = 1'b0;
    logic [31:0] m_lut = '0;
    logic [31:0] parity_lut;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: gather the selected bits of x into a table index, then apply the inversion.
    function automatic logic model_y(input logic [13:0] xv);
        int idx = 0;
        for (int j = 0; j < 5; j++) if (xv[m_sel[j]]) idx += (1 << j);
        return m_lut[idx] ^ m_inv;
    endfunction

    // Scoreboard: handshakes sampled at the falling edge, away from the register updates.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) exp_q.push_back(model_y(bus.x));
            if (bus.out_valid) begin
                if (hold_pending) checkOutput("stall_hold_y", bus.y, hold_y);
                if (bus.out_ready) begin
                    checkOutput("sb_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) checkOutput("sb_y", bus.y, exp_q.pop_front());
                    out_count++;
                end
            end else if (hold_pending) begin
                checkOutput("stall_hold_valid", bus.out_valid, 1);
            end
            hold_pending = bus.out_valid && !bus.out_ready;
            hold_y       = bus.y;
            if (bus.cfg_done) done_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        hold_pending = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic start_cfg(input logic [19:0] sel, input logic inv, input bit good, input string tag);
        bit ok = 1'b0;
        bus.cfg_sel   = sel;
        bus.cfg_inv   = inv;
        bus.cfg_start = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.cfg_ready;
            tick();
        end
        bus.cfg_start = 1'b0;
        checkOutput({tag, "_start_taken"}, ok, 1);
        if (good) begin
            for (int j = 0; j < 5; j++) m_sel[j] = int'(sel[4*j +: 4]);
            m_inv = inv;
        end
    endtask

    task automatic load_lut(input logic [31:0] lut_vec, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus.cfg_bit_vld = 1'b1;
            bus.cfg_bit     = lut_vec[i];
            tick();
        end
        bus.cfg_bit_vld = 1'b0;
        if (nbits == 32) m_lut = lut_vec;
    endtask

    task automatic full_config(input logic [19:0] sel, input logic inv, input logic [31:0] lut_vec, input string tag);
        int d0;
        start_cfg(sel, inv, 1'b1, tag);
        d0 = done_count;
        load_lut(lut_vec, 32);
        tick();
        tick();
        checkOutput({tag, "_done_once"}, done_count - d0, 1);
        checkOutput({tag, "_run_in_ready"}, bus.in_ready, 1);
    endtask

    // One vector with a free output, checking the two-cycle latency and the value.
    task automatic eval_one(input logic [13:0] xv, input logic ye, input string tag);
        bus.out_ready = 1'b1;
        bus.x         = xv;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_in_ready"}, bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_lat1_ovalid"}, bus.out_valid, 0);
        @(negedge clk);
        checkOutput({tag, "_lat2_ovalid"}, bus.out_valid, 1);
        checkOutput({tag, "_y"}, bus.y, ye);
        tick();
    endtask

    task automatic drain(input string tag);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || bus.out_valid); i++) tick();
        checkOutput({tag, "_drained"}, exp_q.size(), 0);
    endtask

    // Random configurations followed by random valid/ready traffic.
    task automatic applyStimulus(input int rounds);
        logic [19:0] sel;
        for (int r = 0; r < rounds; r++) begin
            for (int j = 0; j < 5; j++) sel[4*j +: 4] = 4'($urandom_range(0, 13));
            full_config(sel, 1'($urandom), $urandom, "rand_cfg");
            for (int c = 0; c < 120; c++) begin
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.x         = 14'($urandom);
                bus.out_ready = ($urandom_range(0, 2) != 0);
                tick();
            end
            drain("rand");
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          base;
        int          sent;
        int          d0;
        bit          saw_drop;
        bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [13:0] vecs[6];
        logic [31:0] parity_const = 32'h6996_9669;

        // Table entry i is bit 31-i of the constant: entries are loaded first-to-last.
        for (int i = 0; i < 32; i++) parity_lut[i] = parity_const[31-i];
        for (int j = 0; j < 5; j++) m_sel[j] = 0;

        bus.cfg_start   = 1'b0;
        bus.cfg_sel     = '0;
        bus.cfg_inv     = 1'b0;
        bus.cfg_bit_vld = 1'b0;
        bus.cfg_bit     = 1'b0;
        bus.in_valid    = 1'b0;
        bus.x           = '0;
        bus.out_ready   = 1'b1;

        tick();
        tick();
        checkOutput("rst_in_ready", bus.in_ready, 0);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_y", bus.y, 0);
        checkOutput("rst_cfg_done", bus.cfg_done, 0);
        checkOutput("rst_cfg_err", bus.cfg_err, 0);
        rst_n = 1'b1;
        tick();
        checkOutput("uncfg_cfg_ready", bus.cfg_ready, 1);
        checkOutput("uncfg_in_ready", bus.in_ready, 0);

        $display("[TB] reset in the middle of a load");
        start_cfg(20'hDCBA9, 1'b0, 1'b1, "midload");
        d0 = done_count;
        load_lut(parity_lut, 10);
        do_reset();
        checkOutput("midload_in_ready", bus.in_ready, 0);
        checkOutput("midload_cfg_err", bus.cfg_err, 0);
        checkOutput("midload_cfg_ready", bus.cfg_ready, 1);
        checkOutput("midload_no_done", done_count - d0, 0);
        full_config(20'hDCBA9, 1'b0, parity_lut, "reload");

        $display("[TB] parity table, directed vectors");
        eval_one(14'h0200, 1'b1, "par_0200");
        eval_one(14'h0600, 1'b0, "par_0600");
        eval_one(14'h01FF, 1'b0, "par_01FF");

        full_config(20'hDCBA9, 1'b1, parity_lut, "inv");
        eval_one(14'h0200, 1'b0, "inv_0200");

        $display("[TB] back-to-back stream");
        bus.out_ready = 1'b1;
        base = out_count;
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = (c < 8);
            bus.x        = 14'($urandom);
            @(negedge clk);
            if (c < 8) checkOutput("stream_in_ready", bus.in_ready, 1);
            if (c >= 2) checkOutput("stream_out_valid", bus.out_valid, 1);
            tick();
        end
        bus.in_valid = 1'b0;
        checkOutput("stream_count", out_count - base, 8);

        $display("[TB] stalled output stream");
        for (int i = 0; i < 6; i++) vecs[i] = 14'($urandom);
        sent = 0;
        saw_drop = 1'b0;
        base = out_count;
        for (int c = 0; c < 40 && (out_count - base) < 6; c++) begin
            bus.out_ready = pat[c % 4];
            bus.in_valid  = (sent < 6);
            bus.x         = vecs[sent % 6];
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) sent++;
            else if (bus.in_valid) saw_drop = 1'b1;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checkOutput("stall_in_ready_drop", saw_drop, 1);
        checkOutput("stall_count", out_count - base, 6);

        applyStimulus(3);

        $display("[TB] bad select while running");
        full_config(20'hDCBA9, 1'b0, parity_lut, "pre_err");
        d0 = done_count;
        start_cfg(20'hDCBAE, 1'b1, 1'b0, "bad_sel");
        checkOutput("bad_sel_cfg_err", bus.cfg_err, 1);
        for (int i = 0; i < 4; i++) begin
            bus.cfg_bit_vld = 1'b1;
            bus.cfg_bit     = ~parity_lut[i];
            tick();
        end
        bus.cfg_bit_vld = 1'b0;
        checkOutput("bad_sel_no_done", done_count - d0, 0);
        checkOutput("bad_sel_still_run", bus.in_ready, 1);
        eval_one(14'h0200, 1'b1, "bad_sel_0200");
        checkOutput("bad_sel_err_sticky", bus.cfg_err, 1);

        $display("[TB] start while the output is stalled");
        bus.out_ready = 1'b0;
        bus.x         = 14'h0600;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        for (int i = 0; i < 10 && !bus.out_valid; i++) tick();
        checkOutput("stalled_out_valid", bus.out_valid, 1);
        bus.cfg_sel   = 20'hDCBA9;
        bus.cfg_inv   = 1'b0;
        bus.cfg_start = 1'b1;
        @(negedge clk);
        checkOutput("stalled_cfg_ready_a", bus.cfg_ready, 0);
        tick();
        @(negedge clk);
        checkOutput("stalled_cfg_ready_b", bus.cfg_ready, 0);
        tick();
        bus.out_ready = 1'b1;
        base = out_count;
        full_config(20'hDCBA9, 1'b0, parity_lut, "after_drain");
        checkOutput("after_drain_out", out_count - base, 1);
        checkOutput("after_drain_err_clear", bus.cfg_err, 0);
        eval_one(14'h0600, 1'b0, "final_0600");

        drain("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
